// File: rtl/ddr3_playback_reader.sv
// ddr3_playback_reader: fetches DDR3 words and plays them as DAC samples.
// Define PLAYBACK_LOOP_EN for continuous looping with a stop input.
module ddr3_playback_reader #(
   parameter int ADDR_W    = 29,
   parameter int DATA_W    = 256,
   parameter int SAMPLE_W  = 8,
   parameter int DAC_W     = 12,
   parameter int ADDR_STEP = 8,
   parameter int BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [23:0]       num_words,
   input  logic [15:0]       sample_div,
`ifdef PLAYBACK_LOOP_EN
   input  logic              stop,
`endif
   input  logic              app_rdy,
   output logic              app_en,
   output logic [2:0]        app_cmd,
   output logic [ADDR_W-1:0] app_addr,
   input  logic [DATA_W-1:0] app_rd_data,
   input  logic              app_rd_data_valid,
   output logic [DAC_W-1:0]  ampl,
   output logic              sample_strobe,
   output logic              busy,
   output logic              done,
   output logic              underrun
);
   localparam int SPW   = DATA_W / SAMPLE_W;
   localparam int IDX_W = $clog2(SPW);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(BUF_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPW - 1);

   typedef enum logic [1:0] {IDLE, FILL, PLAY, FINISH} state_t;
   state_t state, state_d;

   logic [23:0]         num_q;
   logic [23:0]         issued;
   logic [15:0]         div_q;
   logic [15:0]         div_cnt;
   logic [CNT_W-1:0]    count;
   logic [CNT_W-1:0]    outstanding;
   logic [CNT_W-1:0]    fill_target;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [IDX_W-1:0]    idx;
   logic [DATA_W-1:0]   buf_mem [BUF_DEPTH];
   logic [SAMPLE_W-1:0] sample;
   logic active, issue_ok, accept, ret, push;
   logic tick, pop, last_pop;
`ifdef PLAYBACK_LOOP_EN
   logic              stop_q;
   logic [ADDR_W-1:0] base_q;
`else
   logic [23:0]       played;
`endif

   assign active = (state == FILL) || (state == PLAY);
   assign fill_target = (num_q >= 24'(BUF_DEPTH)) ?
                        DEPTH : num_q[CNT_W-1:0];

`ifdef PLAYBACK_LOOP_EN
   // after stop, fetch only if the current word is not yet on its way
   assign issue_ok = !stop_q ||
                     (count == '0 && outstanding == '0);
`else
   assign issue_ok = issued < num_q;
`endif

   assign app_en  = active && issue_ok &&
                    (count + outstanding < DEPTH);
   assign app_cmd = 3'b001;
   assign accept  = app_en && app_rdy;
   assign ret     = app_rd_data_valid && (state != IDLE) &&
                    (outstanding != '0);
   assign push    = ret && active;
   assign tick    = (state == PLAY) && (div_cnt == div_q - 16'd1);
   assign pop     = tick && (count != '0) && (idx == LAST_IDX);
   assign sample  = buf_mem[rd_ptr][32'(idx)*SAMPLE_W +: SAMPLE_W];

`ifdef PLAYBACK_LOOP_EN
   assign last_pop = pop && stop_q;
`else
   assign last_pop = pop && (played == num_q - 24'd1);
`endif

   assign busy = (state != IDLE);
   assign done = (state == FINISH) && (outstanding == '0);

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (start)
                     state_d = (num_words == '0) ? FINISH : FILL;
         FILL:    if (count >= fill_target) state_d = PLAY;
         PLAY:    if (last_pop) state_d = FINISH;
         FINISH:  if (outstanding == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) buf_mem[wr_ptr] <= app_rd_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         num_q         <= '0;
         div_q         <= 16'd1;
         app_addr      <= '0;
         issued        <= '0;
         outstanding   <= '0;
         count         <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         idx           <= '0;
         div_cnt       <= '0;
         ampl          <= '0;
         sample_strobe <= 1'b0;
         underrun      <= 1'b0;
`ifdef PLAYBACK_LOOP_EN
         stop_q        <= 1'b0;
         base_q        <= '0;
`else
         played        <= '0;
`endif
      end else begin
         state         <= state_d;
         sample_strobe <= 1'b0;
         if (state == IDLE && start) begin
            num_q    <= num_words;
            div_q    <= (sample_div == '0) ? 16'd1 : sample_div;
            app_addr <= base_addr;
            issued   <= '0;
            idx      <= '0;
            underrun <= 1'b0;
`ifdef PLAYBACK_LOOP_EN
            base_q   <= base_addr;
            stop_q   <= 1'b0;
`else
            played   <= '0;
`endif
         end
`ifdef PLAYBACK_LOOP_EN
         if (busy && stop) stop_q <= 1'b1;
         if (accept) begin
            if (issued == num_q - 24'd1) begin
               issued   <= '0;
               app_addr <= base_q;
            end else begin
               issued   <= issued + 24'd1;
               app_addr <= app_addr + ADDR_W'(ADDR_STEP);
            end
         end
`else
         if (accept) begin
            issued   <= issued + 24'd1;
            app_addr <= app_addr + ADDR_W'(ADDR_STEP);
         end
`endif
         outstanding <= outstanding + CNT_W'(accept) - CNT_W'(ret);
         // leaving PLAY drops any prefetched words
         if (last_pop) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (state != PLAY || tick) div_cnt <= '0;
         else                       div_cnt <= div_cnt + 16'd1;
         if (tick) begin
            if (count != '0) begin
               ampl          <= DAC_W'(sample);
               sample_strobe <= 1'b1;
               idx           <= idx + IDX_W'(1);
`ifndef PLAYBACK_LOOP_EN
               if (pop) played <= played + 24'd1;
`endif
            end else begin
               underrun <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_ddr3_playback_reader.sv
// Bench for ddr3_playback_reader: directed and random playbacks checked
// against a byte-addressed memory model and an expected-sample queue.
module tb_ddr3_playback_reader;
   localparam int AW = 29;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          app_rdy = 1'b1;
   logic [AW-1:0] base_addr = '0;
   logic [23:0]   num_words = '0;
   logic [15:0]   sample_div = '0;
`ifdef PLAYBACK_LOOP_EN
   logic          stop = 1'b0;
`endif
   logic          app_en;
   logic [2:0]    app_cmd;
   logic [AW-1:0] app_addr;
   logic [255:0]  app_rd_data = '0;
   logic          app_rd_data_valid = 1'b0;
   logic [11:0]   ampl;
   logic          sample_strobe, busy, done, underrun;

   int n_pass = 0;
   int n_total = 0;

   ddr3_playback_reader dut (
      .clk(clk), .reset(reset), .start(start),
      .base_addr(base_addr), .num_words(num_words),
      .sample_div(sample_div),
`ifdef PLAYBACK_LOOP_EN
      .stop(stop),
`endif
      .app_rdy(app_rdy), .app_en(app_en), .app_cmd(app_cmd),
      .app_addr(app_addr), .app_rd_data(app_rd_data),
      .app_rd_data_valid(app_rd_data_valid), .ampl(ampl),
      .sample_strobe(sample_strobe), .busy(busy), .done(done),
      .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // memory contents: a scrambled function of the word address
   int unsigned seed;
   function automatic logic [7:0] mem_byte(input logic [AW-1:0] a,
                                           input int b);
      logic [31:0] v;
      v = 32'(a) * 32'd37 + 32'(b) * 32'd11 + seed;
      return v[7:0] ^ v[15:8];
   endfunction

   typedef struct {
      int            due;
      logic [AW-1:0] a;
   } rsp_t;

   int            cyc = 0;
   rsp_t          rq[$];
   logic [AW-1:0] acc_q[$];
   int            cmd_n = 0;
   int            n_fast = 0;
   int            lat_fast = 10;
   int            lat_slow = 10;

   always @(posedge clk) cyc <= cyc + 1;

   // controller model: in-order reads with programmable latency
   always @(negedge clk) begin
      rsp_t r;
      app_rd_data_valid = 1'b0;
      if (rq.size() != 0 && rq[0].due <= cyc) begin
         r = rq.pop_front();
         for (int b = 0; b < 32; b++)
            app_rd_data[b*8 +: 8] = mem_byte(r.a, b);
         app_rd_data_valid = 1'b1;
      end
      if (!reset && app_en && app_rdy) begin
         acc_q.push_back(app_addr);
         r.a = app_addr;
         r.due = cyc + ((cmd_n < n_fast) ? lat_fast : lat_slow);
         rq.push_back(r);
         cmd_n++;
      end
   end

   logic [7:0]  exp_q[$];
   logic [11:0] prev_ampl = '0;
   bit          prev_ok = 1'b0;
   int          strobes = 0;
   int          done_n = 0;
   int          last_t = -1;
   int          spacing = 0;

   always @(negedge clk) begin
      if (done) done_n++;
      if (reset) prev_ok = 1'b0;
      else begin
         if (sample_strobe) begin
            strobes++;
            chk("strobe_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
               chk("sample", 64'(ampl), 64'(exp_q.pop_front()));
            if (spacing != 0 && last_t >= 0)
               chk("spacing", 64'(cyc - last_t), 64'(spacing));
            last_t = cyc;
         end else if (prev_ok) begin
            chk("ampl_hold", 64'(ampl), 64'(prev_ampl));
         end
         prev_ampl = ampl;
         prev_ok = 1'b1;
      end
   end

   task automatic arm(input logic [AW-1:0] base, input int n,
                      input int sp);
      exp_q.delete();
      acc_q.delete();
      cmd_n = 0;
      last_t = -1;
      spacing = sp;
      for (int k = 0; k < n; k++)
         for (int b = 0; b < 32; b++)
            exp_q.push_back(mem_byte(AW'(base + AW'(k * 8)), b));
   endtask

   task automatic kick(input logic [AW-1:0] base, input int n,
                       input int div, input logic rdy);
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = base;
      num_words = 24'(n);
      sample_div = 16'(div);
      app_rdy = rdy;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      int i;
      i = 0;
      while (done_n == d0 && i < budget) begin
         @(posedge clk); #1;
         i++;
      end
      chk("done_seen", 64'(done_n - d0), 64'd1);
   endtask

   task automatic chk_idle();
      chk("rst_app_en", 64'(app_en), 64'd0);
      chk("rst_app_addr", 64'(app_addr), 64'd0);
      chk("rst_ampl", 64'(ampl), 64'd0);
      chk("rst_strobe", 64'(sample_strobe), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_underrun", 64'(underrun), 64'd0);
   endtask

   task automatic play(input logic [AW-1:0] base, input int n,
                       input int div, input logic exp_ur,
                       input int sp, input int stall);
      int d0;
      arm(base, n, sp);
      d0 = done_n;
      kick(base, n, div, stall == 0);
      for (int i = 0; i < stall; i++) begin
         chk("stall_en", 64'(app_en), 64'd1);
         chk("stall_addr", 64'(app_addr), 64'(base));
         @(posedge clk); #1;
      end
      if (stall > 0) begin
         chk("stall_no_cmd", 64'(acc_q.size()), 64'd0);
         app_rdy = 1'b1;
      end
      wait_done(d0, 20000);
      repeat (3) @(posedge clk);
      #1;
      chk("done_once", 64'(done_n - d0), 64'd1);
      chk("samples_left", 64'(exp_q.size()), 64'd0);
      chk("cmd_count", 64'(acc_q.size()), 64'(n));
      for (int k = 0; k < n && k < acc_q.size(); k++)
         chk("cmd_addr", 64'(acc_q[k]), 64'(AW'(base + AW'(k * 8))));
      chk("busy_after", 64'(busy), 64'd0);
      chk("underrun", 64'(underrun), 64'(exp_ur));
   endtask

   initial begin
      logic [AW-1:0] b;
      int n, dv, d0, cnt;
      seed = $urandom;
      repeat (3) @(posedge clk);
      #1;
      chk_idle();
      chk("app_cmd", 64'(app_cmd), 64'd1);
      reset = 1'b0;
      @(posedge clk); #1;
      chk_idle();

      // zero-length playback: one FINISH cycle, no commands
      arm(29'h40, 0, 0);
      d0 = done_n;
      kick(29'h40, 0, 3, 1'b1);
      chk("zero_busy", 64'(busy), 64'd1);
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_app_en", 64'(app_en), 64'd0);
      @(posedge clk); #1;
      chk("zero_idle", 64'(busy), 64'd0);
      chk("zero_done_n", 64'(done_n - d0), 64'd1);
      chk("zero_cmds", 64'(acc_q.size()), 64'd0);

`ifdef PLAYBACK_LOOP_EN
      exp_q.delete();
      acc_q.delete();
      cmd_n = 0;
      last_t = -1;
      spacing = 1;
      for (int k = 0; k < 12; k++)
         for (int bb = 0; bb < 32; bb++)
            exp_q.push_back(mem_byte(AW'(29'h100 + AW'((k % 2) * 8)), bb));
      d0 = done_n;
      cnt = strobes;
      kick(29'h100, 2, 1, 1'b1);
      for (int i = 0; i < 2000 && strobes - cnt < 150; i++) begin
         @(posedge clk); #1;
      end
      chk("loop_reached_150", 64'(strobes - cnt >= 150), 64'd1);
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      wait_done(d0, 2000);
      repeat (3) @(posedge clk);
      #1;
      cnt = strobes - cnt;
      chk("loop_count_mod32", 64'(cnt % 32), 64'd0);
      chk("loop_count_range", 64'(cnt >= 150 && cnt <= 192), 64'd1);
      chk("loop_done_once", 64'(done_n - d0), 64'd1);
      chk("loop_cmds_seen", 64'(acc_q.size() >= 4), 64'd1);
      for (int k = 0; k < acc_q.size(); k++)
         chk("loop_addr", 64'(acc_q[k]),
             64'(AW'(29'h100 + AW'((k % 2) * 8))));
      chk("loop_idle", 64'(busy), 64'd0);
`else
      // reference case from the plan
      play(29'h100, 3, 4, 1'b0, 4, 0);

      // controller back-pressure on the first command
      play(29'h2000, 3, 2, 1'b0, 2, 20);

      // slow returns after the initial fill starve the player
      n_fast = 2;
      lat_slow = 100;
      play(29'h3000, 4, 1, 1'b1, 0, 0);
      n_fast = 0;
      lat_slow = 10;

      // reset in the middle of PLAY with a read still in flight
      arm(29'h5000, 4, 2);
      kick(29'h5000, 4, 2, 1'b1);
      repeat (78) @(posedge clk);
      #1;
      chk("mid_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 40; i++) begin
         chk_idle();
         @(posedge clk); #1;
      end
      for (int i = 0; i < 500 && rq.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      chk_idle();
      play(29'h6000, 3, 3, 1'b0, 3, 0);

      // address wrap across the top of the space
      play(29'h1FFF_FFF8, 3, 1, 1'b0, 1, 0);

      for (int i = 0; i < 4; i++) begin
         b = AW'($urandom) & ~AW'(7);
         n = int'($urandom_range(1, 4));
         dv = int'($urandom_range(0, 5));
         play(b, n, dv, 1'b0, (dv == 0) ? 1 : dv, 0);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
